// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for mem_port_arbiter: two request/ack ports
// (port 0 = CPU load/store, port 1 = loader/DMA). The requesters use the
// master modport and the arbiter uses the slave modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic [DATA_W-1:0] rdata0;
  logic              err0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata1;
  logic              err1;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the shared data port of the 4-module
// 16-bit memory. Each access takes IDLE -> ACCESS -> RESP, which gives one
// access every 3 cycles. Ties are broken by a round-robin pointer. The
// arbiter owns the direction of data_bus and only drives it during a write
// ACCESS cycle.
// Optional feature: define MEMARB_WPROT_EN to reject writes to the
// instruction module (addr[11:10] == 2'b00). A rejected write never strobes
// write_mode, and it is acked with err=1. When the macro is undefined,
// err0/err1 stay 0.
module mem_port_arbiter #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave rq,
  output logic [ADDR_W-1:0] address_bus,
  inout  wire  [DATA_W-1:0] data_bus,
  output logic              write_mode,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d;        // requester that wins a tie
  logic              win_q, win_d;      // requester owning the current access
  logic              we_q, we_d;
  logic              prot_q, prot_d;    // current access is a rejected write
  logic [ADDR_W-1:0] addr_q, addr_d;    // also drives address_bus
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wm_q, wm_d;
  logic              oe_q, oe_d;        // data_bus output enable
  logic              busy_q, busy_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              elig0, elig1, pick;
  logic              sel_we, sel_prot;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Eligibility and winner selection. A requester that is being acked this
  // cycle still holds req high, so it is masked out to prevent serving it twice.
  always_comb begin
    elig0     = rq.req0 & ~ack0_q;
    elig1     = rq.req1 & ~ack1_q;
    pick      = (elig0 & elig1) ? rr_q : elig1;
    sel_we    = pick ? rq.we1    : rq.we0;
    sel_addr  = pick ? rq.addr1  : rq.addr0;
    sel_wdata = pick ? rq.wdata1 : rq.wdata0;
`ifdef MEMARB_WPROT_EN
    sel_prot  = sel_we & (sel_addr[ADDR_W-1 -: 2] == 2'b00);
`else
    sel_prot  = 1'b0;
`endif
  end

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    we_d     = we_q;
    prot_d   = prot_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wm_d     = wm_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        wm_d = 1'b0;
        oe_d = 1'b0;
        if (elig0 | elig1) begin
          win_d   = pick;
          we_d    = sel_we;
          prot_d  = sel_prot;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wm_d    = sel_we & ~sel_prot;
          oe_d    = sel_we & ~sel_prot;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Memory performs the op at the end of this cycle.
        wm_d    = 1'b0;
        oe_d    = 1'b0;
        state_d = RESP;
      end
      RESP: begin
        // The memory read register is on data_bus during this cycle.
        busy_d  = 1'b0;
        rr_d    = ~win_q;
        state_d = IDLE;
        if (win_q) begin
          ack1_d = 1'b1;
          err1_d = prot_q;
          if (!we_q) rdata1_d = data_bus;
        end else begin
          ack0_d = 1'b1;
          err0_d = prot_q;
          if (!we_q) rdata0_d = data_bus;
        end
      end
      default: begin
        wm_d    = 1'b0;
        oe_d    = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs. Reset aborts any access in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= RR_INIT;
      win_q    <= 1'b0;
      we_q     <= 1'b0;
      prot_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wm_q     <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      prot_q   <= prot_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wm_q     <= wm_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign data_bus    = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign address_bus = addr_q;
  assign write_mode  = wm_q;
  assign busy        = busy_q;
  assign rq.ack0     = ack0_q;
  assign rq.ack1     = ack1_q;
  assign rq.err0     = err0_q;
  assign rq.err1     = err1_q;
  assign rq.rdata0   = rdata0_q;
  assign rq.rdata1   = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. It contains a word-addressed memory with a read
// register on data_bus, and a transaction-schedule model of the arbiter that
// is checked on every cycle. Directed tests pin the model with literal values.
module tb_mem_port_arbiter;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam bit RR_INIT = 1'b0;
`ifdef MEMARB_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  [DATA_W-1:0] data_bus;
  logic [ADDR_W-1:0] address_bus;
  logic write_mode, busy;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .rst_n(rst_n), .rq(bus.slave),
    .address_bus(address_bus), .data_bus(data_bus),
    .write_mode(write_mode), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = 16'(i) * 16'h0101 ^ 16'h5A5A;
    if (i == 12'hFFC >> 1) v = 16'hABCD;
    if (i == 0) v = 16'hF0C8;
    return v;
  endfunction

  // ---------------- memory environment ----------------
  logic [15:0] phys [0:2047];
  logic [15:0] rd_q = 16'h0;
  logic        rd_vld = 1'b0;
  logic        busy_prev = 1'b0;
  assign data_bus = rd_vld ? rd_q : 16'hzzzz;

  initial begin
    for (int i = 0; i < 2048; i++) phys[i] <= init_val(i);
    forever begin
      @(posedge clk);
      if (write_mode) phys[address_bus[11:1]] <= data_bus;
      rd_q      <= phys[address_bus[11:1]];
      rd_vld    <= busy && !busy_prev && !write_mode;
      busy_prev <= busy;
    end
  end

  // ---------------- transaction-schedule model ----------------
  // m_g is the edge at which the current access was granted. The access
  // occupies cycle m_g+1, the response occupies cycle m_g+2, and the ack is
  // seen in cycle m_g+3.
  int          cyc = 0;
  int          m_g;
  logic        m_rr, m_win, m_we, m_prot;
  logic [11:0] m_addr;
  logic [15:0] m_wdata, m_rdata0, m_rdata1;
  logic [15:0] mm [0:2047];

  task automatic model_reset();
    m_g = -1000; m_rr = RR_INIT; m_win = 1'b0; m_we = 1'b0; m_prot = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata0 = '0; m_rdata1 = '0;
  endtask

  task automatic model_step();
    int d;
    logic a0, a1, e0, e1, w;
    d = cyc - m_g;
    if (d == 1 && m_we && !m_prot) mm[m_addr[11:1]] = m_wdata;
    if (d == 2) begin
      if (!m_we) begin
        if (m_win) m_rdata1 = mm[m_addr[11:1]];
        else       m_rdata0 = mm[m_addr[11:1]];
      end
      m_rr = ~m_win;
    end
    if (d >= 3) begin
      a0 = (d == 3) && !m_win;
      a1 = (d == 3) && m_win;
      e0 = bus.req0 && !a0;
      e1 = bus.req1 && !a1;
      if (e0 || e1) begin
        w       = (e0 && e1) ? m_rr : e1;
        m_g     = cyc;
        m_win   = w;
        m_we    = w ? bus.we1 : bus.we0;
        m_addr  = w ? bus.addr1 : bus.addr0;
        m_wdata = w ? bus.wdata1 : bus.wdata0;
        m_prot  = WPROT && m_we && (m_addr[11:10] == 2'b00);
      end
    end
    cyc++;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mm[i] = init_val(i);
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  task automatic cmp_cycle();
    int d;
    logic ea0, ea1;
    d   = cyc - m_g;
    ea0 = (d == 3) && !m_win;
    ea1 = (d == 3) && m_win;
    chk("ack0",        32'(bus.ack0),    32'(ea0));
    chk("ack1",        32'(bus.ack1),    32'(ea1));
    chk("err0",        32'(bus.err0),    32'(ea0 && m_prot));
    chk("err1",        32'(bus.err1),    32'(ea1 && m_prot));
    chk("rdata0",      32'(bus.rdata0),  32'(m_rdata0));
    chk("rdata1",      32'(bus.rdata1),  32'(m_rdata1));
    chk("busy",        32'(busy),        32'(d == 1 || d == 2));
    chk("write_mode",  32'(write_mode),  32'(d == 1 && m_we && !m_prot));
    chk("address_bus", 32'(address_bus), 32'(m_addr));
    if (d == 1 && m_we && !m_prot) begin
      chk("data_bus_wr", 32'(data_bus), 32'(m_wdata));
    end else if (d == 1 && m_wdata != 16'h0) begin
      vectors++;
      if (data_bus === m_wdata) begin
        miscompares++;
        $display("FAIL data_bus_released: got %h (latched wdata), expected high-Z", data_bus);
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cmp_cycle();
    end
  end

  int          wm_cnt = 0;
  logic [15:0] wm_data = '0;
  initial forever begin
    @(negedge clk);
    if (write_mode) begin
      wm_cnt++;
      wm_data = data_bus;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic access(input int port, input logic we, input logic [11:0] a,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output logic er, output int lat);
    int t0;
    bit got;
    @(posedge clk); #2;
    if (port == 0) begin bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; end
    else           begin bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; end
    t0 = cyc; got = 1'b0; lat = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port == 0 && bus.ack0) || (port == 1 && bus.ack1)) begin
        got = 1'b1;
        lat = cyc - t0;
        rd  = (port == 0) ? bus.rdata0 : bus.rdata1;
        er  = (port == 0) ? bus.err0 : bus.err1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL ack_timeout: port %0d got no ack in 20 cycles, expected ack", port);
    end
    @(posedge clk); #2;
    if (port == 0) bus.req0 = 1'b0;
    else           bus.req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic er;
    int lat;
    int n;
    int ord [4];
    int tack [4];

    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_addr",  32'(address_bus), 32'h0);
    chk("rst_wm",    32'(write_mode), 32'h0);
    chk("rst_ack0",  32'(bus.ack0), 32'h0);
    chk("rst_rdata0", 32'(bus.rdata0), 32'h0);
    rst_n = 1'b1;

    // Single read on port 0
    access(0, 1'b0, 12'hFFC, 16'hDEAD, rd, er, lat);
    chk("t1_rdata0", 32'(rd), 32'hABCD);
    chk("t1_err0", 32'(er), 32'h0);
    chk("t1_latency", 32'(lat), 32'd3);

    // Write on port 1, then read it back
    wm_cnt = 0;
    access(1, 1'b1, 12'h402, 16'h1234, rd, er, lat);
    chk("t2_wm_cycles", 32'(wm_cnt), 32'd1);
    chk("t2_wm_data", 32'(wm_data), 32'h1234);
    chk("t2_wr_rdata1_unchanged", 32'(rd), 32'h0);
    access(1, 1'b0, 12'h402, 16'hBEEF, rd, er, lat);
    chk("t2_rdata1", 32'(rd), 32'h1234);
    chk("t2_rdata0_unchanged", 32'(bus.rdata0), 32'hABCD);

    // Both requesters held: grants alternate
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h100; bus.wdata0 = 16'h1111;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 12'h800; bus.wdata1 = 16'h2222;
    n = 0;
    for (int k = 0; k < 4; k++) begin ord[k] = -1; tack[k] = 0; end
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.ack0 && n < 4) begin ord[n] = 0; tack[n] = cyc; n++; end
      if (bus.ack1 && n < 4) begin ord[n] = 1; tack[n] = cyc; n++; end
    end
    @(posedge clk); #2;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    repeat (8) @(posedge clk);
    chk("t3_ack_count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) chk("t3_grant_order", 32'(ord[k]), 32'(k % 2));
    for (int k = 1; k < 4; k++) chk("t3_ack_spacing", 32'(tack[k] - tack[k-1]), 32'd3);

    // Reset during ACCESS of a read
    @(posedge clk); #2;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h000; bus.wdata0 = 16'h7777;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 32'h0);
    chk("t4_addr", 32'(address_bus), 32'h0);
    chk("t4_wm", 32'(write_mode), 32'h0);
    chk("t4_rdata0", 32'(bus.rdata0), 32'h0);
    bus.req0 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    access(0, 1'b0, 12'h000, 16'h7777, rd, er, lat);
    chk("t4_rdata0_fresh", 32'(rd), 32'hF0C8);

    // Write to the instruction module, then read it back
    wm_cnt = 0;
    access(0, 1'b1, 12'h000, 16'h5555, rd, er, lat);
    chk("t5_err0", 32'(er), WPROT ? 32'h1 : 32'h0);
    chk("t5_wm_cycles", 32'(wm_cnt), WPROT ? 32'd0 : 32'd1);
    chk("t5_rdata0_unchanged", 32'(rd), 32'hF0C8);
    access(0, 1'b0, 12'h000, 16'hABAB, rd, er, lat);
    chk("t5_readback", 32'(rd), WPROT ? 32'hF0C8 : 32'h5555);
    chk("t5_read_err0", 32'(er), 32'h0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
